// File: rtl/sub_shift_seq.sv
// sub_shift_seq: column-serial AES SubBytes + ShiftRows stage with valid/ready handshakes.
// Define SBOX_OUT_REG_EN to register the S-box outputs before work write-back (adds a DRAIN cycle).
module sub_shift_seq #(
  parameter int unsigned NCOL       = 4,
  parameter int unsigned SBOX_STYLE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NCOL-1:0][3:0][7:0]  in_state,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NCOL-1:0][3:0][7:0]  out_state,
  output logic                       busy
);

  localparam int unsigned BW   = 8;
  localparam int unsigned NROW = 4;
  localparam int unsigned CW   = $clog2(NCOL);
  localparam logic [3:0]  LAMBDA = 4'h8;

  if (NCOL != 4) begin : g_ncol_check
    $error("sub_shift_seq: NCOL must be 4");
  end
  if (SBOX_STYLE > 1) begin : g_style_check
    $error("sub_shift_seq: SBOX_STYLE must be 0 or 1");
  end

  typedef enum logic [1:0] {IDLE, SUB, DRAIN, OUT} state_t;

  state_t                          state;
  logic [CW-1:0]                   col_cnt;
  logic [NCOL-1:0][NROW-1:0][BW-1:0] work;
  logic                            ready_q;
  logic [NROW-1:0][BW-1:0]         sb_in;
  logic [NROW-1:0][BW-1:0]         sb_out;

  function automatic logic [BW-1:0] sbox_rom(input logic [BW-1:0] x);
    logic [127:0] row;
    case (x[7:4])
      4'h0: row = 128'h637c777b_f26b6fc5_3001672b_fed7ab76;
      4'h1: row = 128'hca82c97d_fa5947f0_add4a2af_9ca472c0;
      4'h2: row = 128'hb7fd9326_363ff7cc_34a5e5f1_71d83115;
      4'h3: row = 128'h04c723c3_1896059a_071280e2_eb27b275;
      4'h4: row = 128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84;
      4'h5: row = 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf;
      4'h6: row = 128'hd0efaafb_434d3385_45f9027f_503c9fa8;
      4'h7: row = 128'h51a3408f_929d38f5_bcb6da21_10fff3d2;
      4'h8: row = 128'hcd0c13ec_5f974417_c4a77e3d_645d1973;
      4'h9: row = 128'h60814fdc_222a9088_46eeb814_de5e0bdb;
      4'ha: row = 128'he0323a0a_4906245c_c2d3ac62_9195e479;
      4'hb: row = 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08;
      4'hc: row = 128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a;
      4'hd: row = 128'h703eb566_4803f60e_613557b9_86c11d9e;
      4'he: row = 128'he1f89811_69d98e94_9b1e87e9_ce5528df;
      default: row = 128'h8ca1890d_bfe64268_41992d0f_b054bb16;
    endcase
    return row[{4'hf - x[3:0], 3'b000} +: 8];
  endfunction

  // GF(2^4) arithmetic, polynomial x^4 + x + 1
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf16_mul(a, a);
    a4 = gf16_mul(a2, a2);
    a8 = gf16_mul(a4, a4);
    return gf16_mul(gf16_mul(a8, a4), a2);
  endfunction

  // GF((2^4)^2) with y^2 + y + LAMBDA; byte = {high coeff, low coeff}
  function automatic logic [BW-1:0] tower_mul(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  function automatic logic [BW-1:0] tower_inv(input logic [BW-1:0] a);
    logic [3:0] d, di;
    d  = gf16_mul(gf16_mul(a[7:4], a[7:4]), LAMBDA) ^ gf16_mul(a[7:4], a[3:0]) ^ gf16_mul(a[3:0], a[3:0]);
    di = gf16_inv(d);
    return {gf16_mul(a[7:4], di), gf16_mul(a[3:0] ^ a[7:4], di)};
  endfunction

  function automatic logic [BW-1:0] mat_apply(input logic [63:0] m, input logic [BW-1:0] x);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (x[i]) r = r ^ m[8*i +: 8];
    return r;
  endfunction

  // Isomorphism columns: AES basis x^i maps to beta^i, beta a tower root of the AES polynomial
  function automatic logic [63:0] tower_basis();
    logic [BW-1:0] beta, b2, b4, b8;
    logic [63:0]   m;
    beta = '0;
    for (int c = 2; c < 256; c++) begin
      b2 = tower_mul(8'(c), 8'(c));
      b4 = tower_mul(b2, b2);
      b8 = tower_mul(b4, b4);
      if ((b8 ^ b4 ^ tower_mul(b2, 8'(c)) ^ 8'(c) ^ 8'h01) == 8'h00) beta = 8'(c);
    end
    m = '0;
    m[7:0] = 8'h01;
    for (int i = 1; i < 8; i++) m[8*i +: 8] = tower_mul(m[8*(i-1) +: 8], beta);
    return m;
  endfunction

  function automatic logic [63:0] tower_inverse_basis(input logic [63:0] fwd);
    logic [63:0]   m;
    logic [BW-1:0] t;
    m = '0;
    for (int a = 0; a < 256; a++) begin
      t = mat_apply(fwd, 8'(a));
      for (int j = 0; j < 8; j++) if (t == (8'h01 << j)) m[8*j +: 8] = 8'(a);
    end
    return m;
  endfunction

  function automatic logic [BW-1:0] sbox_comp(input logic [BW-1:0] x, input logic [63:0] fwd,
                                              input logic [63:0] inv);
    logic [BW-1:0] b;
    b = mat_apply(inv, tower_inv(mat_apply(fwd, x)));
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign sb_in = work[col_cnt];

  if (SBOX_STYLE == 1) begin : g_sbox_comp
    localparam logic [63:0] FWD = tower_basis();
    localparam logic [63:0] INV = tower_inverse_basis(FWD);
    for (genvar r = 0; r < NROW; r++) begin : g_row
      assign sb_out[r] = sbox_comp(sb_in[r], FWD, INV);
    end
  end else begin : g_sbox_rom
    for (genvar r = 0; r < NROW; r++) begin : g_row
      assign sb_out[r] = sbox_rom(sb_in[r]);
    end
  end

`ifdef SBOX_OUT_REG_EN
  logic [NROW-1:0][BW-1:0] pipe_data;
  logic [CW-1:0]           pipe_col;
  logic                    pipe_vld;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col_cnt   <= '0;
      work      <= '0;
      ready_q   <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SBOX_OUT_REG_EN
      pipe_data <= '0;
      pipe_col  <= '0;
      pipe_vld  <= 1'b0;
`endif
    end else begin
`ifdef SBOX_OUT_REG_EN
      pipe_vld <= (state == SUB);
      if (state == SUB) begin
        pipe_data <= sb_out;
        pipe_col  <= col_cnt;
      end
      if (pipe_vld) work[pipe_col] <= pipe_data;
`endif
      case (state)
        IDLE: begin
          if (in_valid && ready_q) begin
            work    <= in_state;
            col_cnt <= '0;
            state   <= SUB;
            ready_q <= 1'b0;
            busy    <= 1'b1;
          end
        end
        SUB: begin
`ifndef SBOX_OUT_REG_EN
          work[col_cnt] <= sb_out;
`endif
          col_cnt <= col_cnt + CW'(1);
          if (col_cnt == CW'(NCOL - 1)) begin
`ifdef SBOX_OUT_REG_EN
            state <= DRAIN;
`else
            state     <= OUT;
            out_valid <= 1'b1;
`endif
          end
        end
        DRAIN: begin
          state     <= OUT;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ready_q   <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rst gates acceptance so a handshake can never coincide with reset
  assign in_ready = ready_q & ~rst;

  // ShiftRows is a fixed rewiring of the work register
  always_comb begin
    for (int c = 0; c < NCOL; c++)
      for (int r = 0; r < NROW; r++)
        out_state[c][r] = work[CW'(c + r)][r];
  end

endmodule

// File: doc/sub_shift_seq.md
Name: sub_shift_seq

Overview:
- Multi-cycle SubBytes + ShiftRows stage that sits directly upstream of the MixColumns logic in the AES round datapath.
- Accepts one 128-bit AES state and substitutes one column per cycle through 4 shared S-boxes, so area is 4 S-boxes instead of 16.
- Presents the ShiftRows-permuted result on a valid/ready output.
- Output feeds the column-wise MixColumns stage, or AddRoundKey directly in the final round.

Parameters:
- NCOL, 4, number of columns per state; fixed at 4, and any other value is a synthesis error.
- SBOX_STYLE, 0, 0 = case-table ROM S-box, 1 = composite-field GF((2^4)^2) S-box; both must give identical results.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input state valid.
- in_ready  out  1  block can accept a state.
- in_state  in  4x4x8  input state, indexed [c][r], column c, row r.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_state  out  4x4x8  ShiftRows(SubBytes(in_state)), indexed [c][r].
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - in_ready = 0 during the rst cycle, 1 from the first cycle after reset.
  - out_valid = 0, busy = 0.
  - work register = 0, so out_state = 0.
  - col_cnt = 0.
- FSM states and transitions:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch in_state into work, set col_cnt = 0, go to SUB.
  - SUB: in_ready = 0. Each cycle, work[col_cnt][r] <= sbox(work[col_cnt][r]) for r = 0..3, then col_cnt++. When col_cnt == 3, go to OUT and wrap col_cnt to 0.
  - OUT: out_valid = 1, in_ready = 0. On out_ready, go to IDLE.
- out_state: out_state[c][r] = work[(c+r) mod 4][r]; ShiftRows is pure wiring on the register. Only meaningful while out_valid = 1, but must be held stable while out_valid & !out_ready.
- Latency: input accepted at edge E0, SUB occupies the 4 cycles after E0, out_valid rises after edge E4. That is 5 cycles from acceptance to valid. Throughput is one state per 5 cycles minimum (6 including the return to IDLE).
- No input/output overlap:
  - in_ready is low in SUB and OUT.
  - A new state can be accepted at the earliest in the cycle after the out_valid & out_ready handshake.
- Backpressure: OUT holds indefinitely with out_valid high and out_state unchanged until out_ready.
- in_valid while not IDLE is ignored; the upstream stage must hold its data (standard valid/ready).
- out_ready while not in OUT has no effect.
- rst in any state: next cycle FSM = IDLE, out_valid = 0, col_cnt = 0, work = 0. Any in-flight state is discarded with no output.
- rst has priority over a simultaneous handshake.
- S-box: AES forward S-box (FIPS-197), e.g. sbox(00)=63, sbox(53)=ed, sbox(ff)=16.

Optional Feature:
- Macro: SBOX_OUT_REG_EN.
- Defined:
  - A pipeline register sits between the S-box outputs and the work write-back.
  - SUB issues columns 0..3 on 4 cycles, with write-back one cycle later.
  - A DRAIN state (1 cycle, in_ready = 0, busy = 1) is inserted between SUB and OUT.
  - Latency becomes 6 cycles from acceptance to out_valid.
  - rst also clears the pipeline register.
- Undefined: combinational S-box write-back, no DRAIN state, latency 5 cycles.
- Output values are identical in both builds.

Test Plan:
- FIPS-197 App. B round 1: in_state columns {19 3d e3 be}{a0 f4 e2 2b}{9a c6 8d 2a}{e9 f8 48 08} -> out_state {d4 bf 5d 30}{e0 b4 52 ae}{b8 41 11 f1}{1e 27 98 e5}; out_valid exactly 5 cycles after acceptance (6 with SBOX_OUT_REG_EN).
- All-zero in_state -> all bytes 63. All-ff in_state -> all bytes 16. busy high from the cycle after acceptance until the cycle after the output handshake.
- Backpressure: hold out_ready = 0 for 10 cycles in OUT -> out_valid stays 1, out_state stable, in_ready stays 0. Assert out_ready -> IDLE, in_ready = 1 on the next cycle.
- in_valid held high with new data during SUB -> ignored. The first state's result is unaffected, and the second state is accepted only after the output handshake.
- Assert rst for 1 cycle during SUB at col_cnt = 2 -> next cycle IDLE, out_valid = 0, out_state = 0, no output produced. A subsequent vector completes correctly.
- Back-to-back: 3 random states streamed with out_ready tied 1 -> results match the reference model in order, one result every 6 cycles (7 with SBOX_OUT_REG_EN).
